// File: rtl/sayac_pkg.sv
// Shared types for the sayac_genel stepping engine: FSM states and mode codes.
package sayac_pkg;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    SAY   = 2'd1,
    BITTI = 2'd2
  } durum_t;

  localparam logic MOD_DOGRUSAL = 1'b0;
  localparam logic MOD_ZIKZAK   = 1'b1;

endpackage

// File: rtl/sayac_adim_hesap.sv
// Combinational step evaluator: from a value and the run settings it forms the
// candidate next value and whether taking that step keeps the run inside the
// bounds. Arithmetic is one bit wider than the value so nothing ever wraps.
module sayac_adim_hesap
  import sayac_pkg::*;
#(
  parameter int GENISLIK   = 8,
  parameter int MIKTAR_GEN = 3
) (
  input  logic [GENISLIK-1:0]   deger,
  input  logic                  faz,
  input  logic                  mod,
  input  logic [MIKTAR_GEN-1:0] miktar,
  input  logic                  yon,
  input  logic [GENISLIK-1:0]   alt_sinir,
  input  logic [GENISLIK-1:0]   ust_sinir,
  output logic [GENISLIK-1:0]   sonraki,
  output logic                  gecerli
);

  logic [GENISLIK:0] genis;
  logic [GENISLIK:0] adim;
  logic [GENISLIK:0] aday;
  logic              geri_adim;
  logic              artir;

  // Zigzag back-step (opposite direction, size 1) only in phase 1 and only
  // when the forward amount is larger than 1; otherwise it is a plain step.
  // A zero amount or an out-of-bounds current value never yields a legal step.
  always_comb begin
    geri_adim = (mod != MOD_DOGRUSAL) && faz && (miktar != MIKTAR_GEN'(1));
    adim      = geri_adim ? (GENISLIK+1)'(1) : (GENISLIK+1)'(miktar);
    artir     = geri_adim ? ~yon : yon;
    genis     = {1'b0, deger};
    aday      = artir ? (genis + adim) : (genis - adim);
    sonraki   = aday[GENISLIK-1:0];
    gecerli   = (miktar != '0) &&
                (deger >= alt_sinir) && (deger <= ust_sinir) &&
                (aday >= {1'b0, alt_sinir}) && (aday <= {1'b0, ust_sinir});
  end

endmodule

// File: rtl/sayac_genel.sv
// Parametrised stepping counter: loads a start value, then steps linearly or
// in zigzag inside latched bounds until the next step would leave them.
// Optional abort input enabled by defining SAYAC_DURDUR_EN.
module sayac_genel
  import sayac_pkg::*;
#(
  parameter int GENISLIK   = 8,
  parameter int MIKTAR_GEN = 3,
  parameter int ADIM_GEN   = GENISLIK + 2
) (
  input  logic                  saat,
  input  logic                  reset,
  input  logic                  basla,
  input  logic [GENISLIK-1:0]   baslangic_degeri,
  input  logic [GENISLIK-1:0]   alt_sinir,
  input  logic [GENISLIK-1:0]   ust_sinir,
  input  logic                  yon,
  input  logic [MIKTAR_GEN-1:0] miktar,
  input  logic                  mod,
  input  logic                  durdur,
  output logic [GENISLIK-1:0]   sonuc,
  output logic                  hazir,
  output logic                  mesgul,
  output logic                  bitti,
  output logic                  hata,
  output logic [ADIM_GEN-1:0]   adim_sayisi
);

  durum_t                durum_q, durum_d;
  logic                  faz_q, faz_d;
  logic                  yon_q, yon_d;
  logic [MIKTAR_GEN-1:0] miktar_q, miktar_d;
  logic                  mod_q, mod_d;
  logic [GENISLIK-1:0]   alt_q, alt_d;
  logic [GENISLIK-1:0]   ust_q, ust_d;
  logic                  sinir_disi_q, sinir_disi_d;
  logic [GENISLIK-1:0]   sonuc_d;
  logic                  hazir_d, mesgul_d, bitti_d, hata_d;
  logic [ADIM_GEN-1:0]   adim_d;

  logic [GENISLIK-1:0]   simdi_sonraki;
  logic                  simdi_gecerli;
  logic                  faz_sonra;
  logic                  bos;
  logic                  durdur_etkin;
  logic                  ileri_gecerli;
  logic [GENISLIK-1:0]   ileri_sonraki_unused;

`ifdef SAYAC_DURDUR_EN
  assign durdur_etkin = durdur;
`else
  logic durdur_unused;
  assign durdur_unused = durdur;
  assign durdur_etkin  = 1'b0;
`endif

  assign bos       = (durum_q == BOS);
  assign faz_sonra = (mod_q == MOD_ZIKZAK) ? ~faz_q : faz_q;

  sayac_adim_hesap #(.GENISLIK(GENISLIK), .MIKTAR_GEN(MIKTAR_GEN)) u_simdi (
    .deger     (sonuc),
    .faz       (faz_q),
    .mod       (mod_q),
    .miktar    (miktar_q),
    .yon       (yon_q),
    .alt_sinir (alt_q),
    .ust_sinir (ust_q),
    .sonraki   (simdi_sonraki),
    .gecerli   (simdi_gecerli)
  );

  // Lookahead sees the value about to be written: the start value with the
  // fresh inputs on the load edge, otherwise the accepted candidate.
  sayac_adim_hesap #(.GENISLIK(GENISLIK), .MIKTAR_GEN(MIKTAR_GEN)) u_ileri (
    .deger     (bos ? baslangic_degeri : simdi_sonraki),
    .faz       (bos ? 1'b0 : faz_sonra),
    .mod       (bos ? mod : mod_q),
    .miktar    (bos ? miktar : miktar_q),
    .yon       (bos ? yon : yon_q),
    .alt_sinir (bos ? alt_sinir : alt_q),
    .ust_sinir (bos ? ust_sinir : ust_q),
    .sonraki   (ileri_sonraki_unused),
    .gecerli   (ileri_gecerli)
  );

  // State and output registers; everything clears on a synchronous reset.
  always_ff @(posedge saat) begin
    if (reset) begin
      durum_q      <= BOS;
      faz_q        <= 1'b0;
      yon_q        <= 1'b0;
      miktar_q     <= '0;
      mod_q        <= 1'b0;
      alt_q        <= '0;
      ust_q        <= '0;
      sinir_disi_q <= 1'b0;
      sonuc        <= '0;
      hazir        <= 1'b0;
      mesgul       <= 1'b0;
      bitti        <= 1'b0;
      hata         <= 1'b0;
      adim_sayisi  <= '0;
    end else begin
      durum_q      <= durum_d;
      faz_q        <= faz_d;
      yon_q        <= yon_d;
      miktar_q     <= miktar_d;
      mod_q        <= mod_d;
      alt_q        <= alt_d;
      ust_q        <= ust_d;
      sinir_disi_q <= sinir_disi_d;
      sonuc        <= sonuc_d;
      hazir        <= hazir_d;
      mesgul       <= mesgul_d;
      bitti        <= bitti_d;
      hata         <= hata_d;
      adim_sayisi  <= adim_d;
    end
  end

  // Next-state and next-output logic; hazir is a registered lookahead that
  // goes high on the edge writing a value with no legal successor.
  always_comb begin
    durum_d      = durum_q;
    faz_d        = faz_q;
    yon_d        = yon_q;
    miktar_d     = miktar_q;
    mod_d        = mod_q;
    alt_d        = alt_q;
    ust_d        = ust_q;
    sinir_disi_d = sinir_disi_q;
    sonuc_d      = sonuc;
    hazir_d      = hazir;
    mesgul_d     = mesgul;
    adim_d       = adim_sayisi;
    bitti_d      = 1'b0;
    hata_d       = 1'b0;

    case (durum_q)
      BOS: begin
        hazir_d = 1'b0;
        if (basla) begin
          yon_d        = yon;
          miktar_d     = miktar;
          mod_d        = mod;
          alt_d        = alt_sinir;
          ust_d        = ust_sinir;
          sinir_disi_d = (baslangic_degeri < alt_sinir) || (baslangic_degeri > ust_sinir);
          sonuc_d      = baslangic_degeri;
          adim_d       = '0;
          faz_d        = 1'b0;
          mesgul_d     = 1'b1;
          hazir_d      = ~ileri_gecerli;
          durum_d      = SAY;
        end
      end
      SAY: begin
        if (durdur_etkin) begin
          hazir_d  = 1'b0;
          mesgul_d = 1'b0;
          bitti_d  = 1'b1;
          durum_d  = BITTI;
        end else if (simdi_gecerli) begin
          sonuc_d = simdi_sonraki;
          faz_d   = faz_sonra;
          hazir_d = ~ileri_gecerli;
          if (adim_sayisi != '1) begin
            adim_d = adim_sayisi + ADIM_GEN'(1);
          end
        end else begin
          hazir_d  = 1'b0;
          mesgul_d = 1'b0;
          bitti_d  = 1'b1;
          hata_d   = sinir_disi_q;
          durum_d  = BITTI;
        end
      end
      BITTI: begin
        hazir_d = 1'b0;
        durum_d = BOS;
      end
      default: begin
        durum_d = BOS;
      end
    endcase
  end

endmodule
